// File: rtl/minimac2_mdio.sv
// Clause-22 MDIO master: one cmd_start pulse runs a full 64-bit read or write frame on MDC/MDIO.
// Latency: done pulses 1+128*CLK_DIV cycles after acceptance; cmd_start is ignored while busy.
module minimac2_mdio #(
    parameter int CLK_DIV = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_start,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        rd_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [63:0] frame_q, frame_d;
    logic        write_q, write_d;
    logic        mdc_q, mdc_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        done_q, done_d;
    logic [15:0] rx_q, rx_d;
    logic        ta_q, ta_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rd_err_q, rd_err_d;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '1;
            write_q   <= 1'b0;
            mdc_q     <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            done_q    <= 1'b0;
            rx_q      <= '0;
            ta_q      <= 1'b0;
            rdata_q   <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            write_q   <= write_d;
            mdc_q     <= mdc_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
            done_q    <= done_d;
            rx_q      <= rx_d;
            ta_q      <= ta_d;
            rdata_q   <= rdata_d;
            rd_err_q  <= rd_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        write_d   = write_q;
        mdc_d     = mdc_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        done_d    = 1'b0;
        rx_d      = rx_q;
        ta_d      = ta_q;
        rdata_d   = rdata_q;
        rd_err_d  = rd_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    state_d   = SHIFT;
                    // Read frames carry ones in the TA/data slots; the line is released there anyway.
                    frame_d   = {32'hFFFF_FFFF, 2'b01,
                                 cmd_write ? 2'b01 : 2'b10,
                                 cmd_phyad, cmd_regad,
                                 cmd_write ? 2'b10 : 2'b11,
                                 cmd_write ? cmd_wdata : 16'hFFFF};
                    write_d   = cmd_write;
                    div_d     = '0;
                    bit_d     = '0;
                    mdc_d     = 1'b0;
                    mdio_o_d  = 1'b1;
                    mdio_oe_d = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    mdc_d = ~mdc_q;
                    if (!mdc_q) begin
                        // Rising MDC edge: sample the PHY.
                        rx_d = {rx_q[14:0], mdio_i};
                        if (bit_q == 6'd47) begin
                            ta_d = mdio_i;
                        end
                    end else if (bit_q == 6'd63) begin
                        state_d   = IDLE;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b0;
                        done_d    = 1'b1;
                        if (!write_q) begin
                            rdata_d  = rx_q;
                            rd_err_d = ta_q;
                        end
                    end else begin
                        bit_d     = bit_q + 6'd1;
                        frame_d   = {frame_q[62:0], 1'b1};
                        mdio_o_d  = frame_q[62];
                        mdio_oe_d = write_q || (bit_q < 6'd45);
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign rd_err  = rd_err_q;
    assign mdc     = mdc_q;
    assign mdio_o  = mdio_o_q;
    assign mdio_oe = mdio_oe_q;

endmodule
